// File: rtl/alarm_pkg.sv
// Shared types and constants for the anti-theft alarm sequencer.
// State encoding is visible on state_dbg; ARMED must stay at zero.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_ARMED          = 3'd0,
    ST_ENTRY          = 3'd1,
    ST_ALARM          = 3'd2,
    ST_DIS_IGN_ON     = 3'd3,
    ST_DIS_WAIT_OPEN  = 3'd4,
    ST_DIS_WAIT_CLOSE = 3'd5,
    ST_ARM_WAIT       = 3'd6
  } state_t;

  localparam logic [1:0] IDX_ARM    = 2'd0;
  localparam logic [1:0] IDX_DRIVER = 2'd1;
  localparam logic [1:0] IDX_PASS   = 2'd2;
  localparam logic [1:0] IDX_ALARM  = 2'd3;

  localparam logic [3:0] DEF_ARM    = 4'd6;
  localparam logic [3:0] DEF_DRIVER = 4'd8;
  localparam logic [3:0] DEF_PASS   = 4'd15;
  localparam logic [3:0] DEF_ALARM  = 4'd10;

  // A zero interval would never expire sensibly; store it as one second.
  function automatic logic [3:0] clamp_interval(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/alarm_sequencer_time_param_regs.sv
// User-programmable interval store: four 4-bit seconds values.
// Single write port with zero clamp, combinational indexed read.
module time_param_regs
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DEF    = DEF_ARM,
  parameter logic [3:0] T_DRIVER_DEF = DEF_DRIVER,
  parameter logic [3:0] T_PASS_DEF   = DEF_PASS,
  parameter logic [3:0] T_ALARM_DEF  = DEF_ALARM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [1:0] wsel_i,
  input  logic [3:0] wval_i,
  input  logic [1:0] rsel_i,
  output logic [3:0] rval_o
);

  logic [3:0] iv_q [4];

  // Load defaults on reset, otherwise accept clamped writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q[IDX_ARM]    <= T_ARM_DEF;
      iv_q[IDX_DRIVER] <= T_DRIVER_DEF;
      iv_q[IDX_PASS]   <= T_PASS_DEF;
      iv_q[IDX_ALARM]  <= T_ALARM_DEF;
    end else if (we_i) begin
      iv_q[wsel_i] <= clamp_interval(wval_i);
    end
  end

  assign rval_o = iv_q[rsel_i];

endmodule

// File: rtl/alarm_sequencer.sv
// Top-level anti-theft control FSM: doors/ignition in, siren/LED out.
// Also sequences the shared countdown timer via start/duration.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DEF    = DEF_ARM,
  parameter logic [3:0] T_DRIVER_DEF = DEF_DRIVER,
  parameter logic [3:0] T_PASS_DEF   = DEF_PASS,
  parameter logic [3:0] T_ALARM_DEF  = DEF_ALARM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
  input  logic [1:0] time_sel,
  input  logic [3:0] time_value,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic       timer_start,
  output logic [3:0] timer_duration,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state_dbg
);

  state_t     state_q, state_d;
  logic       cd_q, cd_d;
  logic       start_q, start_d;
  logic [3:0] dur_q, dur_d;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic [1:0] sel_d;
  logic [3:0] iv_rd;
  logic       cancel;
  logic       exp_ok;
  logic       closed;

  time_param_regs #(
    .T_ARM_DEF    (T_ARM_DEF),
    .T_DRIVER_DEF (T_DRIVER_DEF),
    .T_PASS_DEF   (T_PASS_DEF),
    .T_ALARM_DEF  (T_ALARM_DEF)
  ) u_regs (
    .clk    (clk),
    .rst    (rst),
    .we_i   (reprogram),
    .wsel_i (time_sel),
    .wval_i (time_value),
    .rsel_i (sel_d),
    .rval_o (iv_rd)
  );

  // An expiry counts only for a live countdown not restarted this cycle.
  assign exp_ok = expired & cd_q & ~start_q;
  assign closed = ~door_driver & ~door_pass;
  assign dur_d  = start_d ? iv_rd : dur_q;

  // Next state, countdown control and registered output values.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    start_d = 1'b0;
    sel_d   = IDX_ARM;
    cancel  = 1'b0;
    siren_d = 1'b0;
    led_d   = 1'b0;
    if (reprogram) begin
      state_d = ST_ARMED;
      cancel  = 1'b1;
    end else if (ignition) begin
      state_d = ST_DIS_IGN_ON;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          unique case (1'b1)
            door_driver: begin
              state_d = ST_ENTRY;
              start_d = 1'b1;
              sel_d   = IDX_DRIVER;
            end
            door_pass: begin
              state_d = ST_ENTRY;
              start_d = 1'b1;
              sel_d   = IDX_PASS;
            end
            default: ;
          endcase
        end
        ST_ENTRY: begin
          if (exp_ok) state_d = ST_ALARM;
        end
        ST_ALARM: begin
          if (exp_ok) begin
            state_d = ST_ARMED;
          end else if (closed && !cd_q) begin
            start_d = 1'b1;
            sel_d   = IDX_ALARM;
          end else if (!closed) begin
            cancel = 1'b1;
          end
        end
        ST_DIS_IGN_ON: state_d = ST_DIS_WAIT_OPEN;
        ST_DIS_WAIT_OPEN: begin
          if (door_driver) state_d = ST_DIS_WAIT_CLOSE;
        end
        ST_DIS_WAIT_CLOSE: begin
          if (closed) begin
            state_d = ST_ARM_WAIT;
            start_d = 1'b1;
            sel_d   = IDX_ARM;
          end
        end
        ST_ARM_WAIT: begin
          if (exp_ok) state_d = ST_ARMED;
          else if (!closed) state_d = ST_DIS_WAIT_CLOSE;
        end
        default: state_d = ST_ARMED;
      endcase
    end
    if (start_d) cd_d = 1'b1;
    else if (state_d != state_q || cancel) cd_d = 1'b0;
    siren_d = (state_d == ST_ALARM);
    if (state_d == ST_ENTRY || state_d == ST_ALARM) begin
      led_d = 1'b1;
    end else if (state_d == ST_ARMED && state_q == ST_ARMED
                 && !reprogram) begin
      led_d = led_q ^ one_hz_enable;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARMED;
      cd_q    <= 1'b0;
      start_q <= 1'b0;
      dur_q   <= T_ARM_DEF;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      start_q <= start_d;
      dur_q   <= dur_d;
      siren_q <= siren_d;
      led_q   <= led_d;
    end
  end

  assign timer_start    = start_q;
  assign timer_duration = dur_q;
  assign siren          = siren_q;
  assign status_led     = led_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a per-cycle reference model.
// Literal checks pin key scenario values; the model checks every cycle.
module tb_alarm_sequencer;

  localparam int S_ARMED = 0;
  localparam int S_ENTRY = 1;
  localparam int S_ALARM = 2;
  localparam int S_IGN   = 3;
  localparam int S_WOPEN = 4;
  localparam int S_WCLS  = 5;
  localparam int S_AWAIT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ignition = 1'b0;
  logic       door_driver = 1'b0;
  logic       door_pass = 1'b0;
  logic       reprogram = 1'b0;
  logic [1:0] time_sel = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       expired = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic       timer_start;
  logic [3:0] timer_duration;
  logic       siren;
  logic       status_led;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int m_state;
  int m_siren;
  int m_led;
  int m_start;
  int m_dur;
  int m_cd;
  int m_iv [4];

  alarm_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .reprogram      (reprogram),
    .time_sel       (time_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .timer_start    (timer_start),
    .timer_duration (timer_duration),
    .siren          (siren),
    .status_led     (status_led),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int  ns;
    bit  valid;
    bit  closed;
    bit  begin_cd;
    bit  cancel;
    int  nd;
    if (rst) begin
      m_state = S_ARMED;
      m_siren = 0;
      m_led   = 0;
      m_start = 0;
      m_dur   = 6;
      m_cd    = 0;
      m_iv[0] = 6;
      m_iv[1] = 8;
      m_iv[2] = 15;
      m_iv[3] = 10;
      return;
    end
    valid    = expired && m_cd == 1 && m_start == 0;
    closed   = !door_driver && !door_pass;
    ns       = m_state;
    begin_cd = 0;
    cancel   = 0;
    nd       = m_dur;
    if (reprogram) begin
      ns     = S_ARMED;
      cancel = 1;
    end else if (ignition) begin
      ns = S_IGN;
    end else if (m_state == S_ARMED) begin
      if (door_driver || door_pass) begin
        ns       = S_ENTRY;
        begin_cd = 1;
        nd       = door_driver ? m_iv[1] : m_iv[2];
      end
    end else if (m_state == S_ENTRY) begin
      if (valid) ns = S_ALARM;
    end else if (m_state == S_ALARM) begin
      if (valid) ns = S_ARMED;
      else if (closed && m_cd == 0) begin
        begin_cd = 1;
        nd       = m_iv[3];
      end else if (!closed) cancel = 1;
    end else if (m_state == S_IGN) begin
      ns = S_WOPEN;
    end else if (m_state == S_WOPEN) begin
      if (door_driver) ns = S_WCLS;
    end else if (m_state == S_WCLS) begin
      if (closed) begin
        ns       = S_AWAIT;
        begin_cd = 1;
        nd       = m_iv[0];
      end
    end else if (m_state == S_AWAIT) begin
      if (valid) ns = S_ARMED;
      else if (!closed) ns = S_WCLS;
    end
    m_siren = (ns == S_ALARM) ? 1 : 0;
    if (ns == S_ENTRY || ns == S_ALARM) m_led = 1;
    else if (ns == S_ARMED && m_state == S_ARMED && !reprogram)
      m_led = one_hz_enable ? 1 - m_led : m_led;
    else m_led = 0;
    if (begin_cd) m_cd = 1;
    else if (ns != m_state || cancel) m_cd = 0;
    m_start = begin_cd ? 1 : 0;
    m_dur   = nd;
    if (reprogram)
      m_iv[time_sel] = (time_value == 0) ? 1 : int'(time_value);
    m_state = ns;
  endtask

  always @(posedge clk) model_step();

  // Whole-output comparison against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (int'(state_dbg) != m_state || int'(siren) != m_siren ||
          int'(status_led) != m_led || int'(timer_start) != m_start ||
          int'(timer_duration) != m_dur) begin
        n_fail++;
        $display("FAIL model t=%0t got st=%0d sir=%0d led=%0d st=%0d dur=%0d expected st=%0d sir=%0d led=%0d st=%0d dur=%0d",
                 $time, state_dbg, siren, status_led, timer_start,
                 timer_duration, m_state, m_siren, m_led, m_start, m_dur);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic e = 1'b0, input logic h = 1'b0,
                      input logic r = 1'b0, input logic [1:0] s = 2'd0,
                      input logic [3:0] v = 4'd0);
    expired       = e;
    one_hz_enable = h;
    reprogram     = r;
    time_sel      = s;
    time_value    = v;
    @(posedge clk);
    @(negedge clk);
    expired       = 1'b0;
    one_hz_enable = 1'b0;
    reprogram     = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_state", int'(state_dbg), S_ARMED);
    chk("rst_siren", int'(siren), 0);
    chk("rst_led", int'(status_led), 0);
    chk("rst_start", int'(timer_start), 0);
    chk("rst_dur", int'(timer_duration), 6);
    rst = 1'b0;

    // Driver entry, expiry raises alarm, closed doors start hold time.
    door_driver = 1'b1;
    tick();
    chk("drv_state", int'(state_dbg), S_ENTRY);
    chk("drv_start", int'(timer_start), 1);
    chk("drv_dur", int'(timer_duration), 8);
    door_driver = 1'b0;
    tick();
    chk("drv_start_pulse", int'(timer_start), 0);
    tick(1'b1);
    chk("alarm_state", int'(state_dbg), S_ALARM);
    chk("alarm_siren", int'(siren), 1);
    tick();
    chk("hold_start", int'(timer_start), 1);
    chk("hold_dur", int'(timer_duration), 10);

    // Reopen cancels hold; later expiry is stale.
    door_pass = 1'b1;
    tick();
    tick(1'b1);
    chk("cancel_state", int'(state_dbg), S_ALARM);
    chk("cancel_siren", int'(siren), 1);
    door_pass = 1'b0;
    tick();
    chk("rehold_start", int'(timer_start), 1);
    tick();
    tick(1'b1);
    chk("rearm_state", int'(state_dbg), S_ARMED);
    chk("rearm_siren", int'(siren), 0);

    // Disarm path through to arm wait and a cancelled countdown.
    ignition = 1'b1;
    tick();
    chk("ign_state", int'(state_dbg), S_IGN);
    chk("ign_led", int'(status_led), 0);
    ignition = 1'b0;
    tick();
    door_driver = 1'b1;
    tick();
    door_driver = 1'b0;
    tick();
    chk("await_state", int'(state_dbg), S_AWAIT);
    chk("await_dur", int'(timer_duration), 6);
    tick();
    door_pass = 1'b1;
    tick();
    chk("await_cancel", int'(state_dbg), S_WCLS);
    tick(1'b1);
    chk("stale_exp", int'(state_dbg), S_WCLS);
    door_pass = 1'b0;
    tick();
    tick();
    tick(1'b1);
    chk("await_done", int'(state_dbg), S_ARMED);

    // Reprogram passenger to 3, arm to 0 (stored as 1).
    tick(1'b0, 1'b0, 1'b1, 2'd2, 4'd3);
    door_pass = 1'b1;
    tick();
    chk("pass_dur", int'(timer_duration), 3);
    door_pass = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
    chk("reprog_state", int'(state_dbg), S_ARMED);
    chk("reprog_led", int'(status_led), 0);
    ignition = 1'b1;
    tick();
    ignition = 1'b0;
    tick();
    door_driver = 1'b1;
    tick();
    door_driver = 1'b0;
    tick();
    chk("clamp_dur", int'(timer_duration), 1);
    tick(1'b1);
    chk("same_cycle_exp", int'(state_dbg), S_AWAIT);
    tick(1'b1);
    chk("arm_after_clamp", int'(state_dbg), S_ARMED);

    // Ignition beats expiry in ENTRY; reprogram beats ignition.
    door_driver = 1'b1;
    tick();
    door_driver = 1'b0;
    tick();
    ignition = 1'b1;
    tick(1'b1);
    chk("ign_vs_exp", int'(state_dbg), S_IGN);
    chk("ign_vs_exp_siren", int'(siren), 0);
    tick(1'b0, 1'b0, 1'b1, 2'd1, 4'd8);
    chk("reprog_vs_ign", int'(state_dbg), S_ARMED);
    ignition = 1'b0;
    tick();

    // LED blink in ARMED.
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1);
      chk("blink", int'(status_led), (i % 2 == 0) ? 1 : 0);
      tick();
    end

    // Reset from ALARM restores defaults.
    door_driver = 1'b1;
    tick();
    door_driver = 1'b0;
    tick();
    tick(1'b1);
    chk("pre_rst_alarm", int'(state_dbg), S_ALARM);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", int'(state_dbg), S_ARMED);
    chk("mid_rst_siren", int'(siren), 0);
    chk("mid_rst_dur", int'(timer_duration), 6);
    door_pass = 1'b1;
    tick();
    chk("def_pass", int'(timer_duration), 15);
    door_pass = 1'b0;
    ignition = 1'b1;
    tick();
    ignition = 1'b0;
    tick();
    door_driver = 1'b1;
    tick();
    door_driver = 1'b0;
    tick();
    chk("def_arm", int'(timer_duration), 6);
    tick(1'b1);
    tick(1'b1);
    door_driver = 1'b1;
    tick();
    chk("def_drv", int'(timer_duration), 8);
    door_driver = 1'b0;
    tick();
    tick(1'b1);
    tick();
    chk("def_alarm", int'(timer_duration), 10);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
